// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    // Default halt encoding; truncated to the instance width, so valid for IW up to 64.
    localparam logic [63:0] HALT_WORD_ALL_ONES = '1;

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decoder handshake: registered instruction with valid/ready flow control.
interface fetch_if #(
    parameter int IW = 32,
    parameter int AW = 6
);
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;

    modport master (output instr_valid, output instr, output instr_pc, input instr_ready);
    modport slave  (input instr_valid, input instr, input instr_pc, output instr_ready);
endinterface

// File: rtl/fetch_imem.sv
// Instruction memory: combinational read, synchronous write, old data on read/write collision.
module fetch_imem #(
    parameter int IW    = 32,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);
    logic [IW-1:0] mem [DEPTH];

    // NOTE: the array has no reset; program contents must survive clkreset and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The write lands at the clock edge, so a same-cycle read still sees the old word.
    assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, FSM (IDLE/RUN/HALTED), on-chip IMEM and a registered
// valid/ready output with redirect, back-pressure and halt-word detection.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int IW                 = 32,
    parameter int DEPTH              = 64,
    localparam int AW                = $clog2(DEPTH),
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter logic [IW-1:0] HALT_WORD = IW'(HALT_WORD_ALL_ONES)
) (
    input  logic          clk,
    input  logic          clkreset,
    input  logic          run,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    input  logic          imem_we,
    input  logic [AW-1:0] imem_waddr,
    input  logic [IW-1:0] imem_wdata,
    fetch_if.master       dec,
    output logic          halted
);
    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_RUN    = RUN;
    localparam logic [1:0] ST_HALTED = HALTED;

    logic [1:0]    state;
    logic [AW-1:0] pc;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [IW-1:0] mem_word;
    logic          slot_free;

    fetch_imem #(
        .IW    (IW),
        .DEPTH (DEPTH)
    ) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (imem_waddr),
        .wdata (imem_wdata),
        .raddr (pc),
        .rdata (mem_word)
    );

    // The output register can take a new word when empty or being drained this cycle.
    assign slot_free = !out_valid || dec.instr_ready;

    always_ff @(posedge clk or negedge clkreset) begin
        if (!clkreset) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            halted    <= 1'b0;
        end else begin
            // NOTE: the last non-blocking assignment in a block wins, so this handshake clear acts
            // as a default that the redirect flush and a new fetch below override.
            if (out_valid && dec.instr_ready) begin
                out_valid <= 1'b0;
            end

            if (redirect_valid) begin
                pc        <= redirect_pc;
                out_valid <= 1'b0;
                state     <= run ? ST_RUN : ST_IDLE;
                halted    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (run) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (!run) begin
                            state <= ST_IDLE;
                        end else if (slot_free) begin
                            out_instr <= mem_word;
                            out_pc    <= pc;
                            out_valid <= 1'b1;
                            if (mem_word == HALT_WORD) begin
                                // PC stays on the halt word so a later redirect decides where to go.
                                state  <= ST_HALTED;
                                halted <= 1'b1;
                            end else begin
                                pc <= (pc == AW'(DEPTH - 1)) ? '0 : pc + 1'b1;
                            end
                        end
                    end
                    ST_HALTED: begin
                        // Only redirect or reset leaves this state.
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign dec.instr_valid = out_valid;
    assign dec.instr       = out_instr;
    assign dec.instr_pc    = out_pc;
endmodule
